// File: rtl/thresholding_cfg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | thresholding_cfg_loader: quiesces the thresholding core, then streams a   |
// | full threshold table into its cfg port; host cfg accesses always win.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module thresholding_cfg_loader #(
  parameter int input_BDIM   = 1,
  parameter int input_SDIM   = 1,
  parameter int output_WIDTH = 1,
  parameter int T_WIDTH      = 8,
  parameter int MAX_INFLIGHT = 16,
  localparam int CF  = input_BDIM / input_SDIM,
  localparam int PEB = $clog2(input_SDIM),
  localparam int CFB = $clog2(CF),
  localparam int OB  = output_WIDTH,
  localparam int NT  = 2**OB - 1,
  localparam int AW  = CFB + PEB + OB
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_len_o,
  input  logic               wstrm_tvalid_i,
  output logic               wstrm_tready_o,
  input  logic [T_WIDTH-1:0] wstrm_tdata_i,
  input  logic               wstrm_tlast_i,
  input  logic               host_en_i,
  input  logic               host_we_i,
  input  logic [AW-1:0]      host_a_i,
  input  logic [T_WIDTH-1:0] host_d_i,
  output logic               host_rack_o,
  output logic [T_WIDTH-1:0] host_q_o,
  output logic               cfg_en_o,
  output logic               cfg_we_o,
  output logic [AW-1:0]      cfg_a_o,
  output logic [T_WIDTH-1:0] cfg_d_o,
  input  logic               cfg_rack_i,
  input  logic [T_WIDTH-1:0] cfg_q_i,
  input  logic               up_tvalid_i,
  output logic               up_tready_o,
  output logic               core_tvalid_o,
  input  logic               core_tready_i,
  input  logic               out_tvalid_i,
  input  logic               out_tready_i
);

  localparam int IW  = $clog2(MAX_INFLIGHT + 1);
  localparam int PEW = (PEB > 0) ? PEB : 1;
  localparam int CFW = (CFB > 0) ? CFB : 1;

  localparam logic [OB-1:0]  T_LAST  = OB'(NT - 1);
  localparam logic [PEW-1:0] PE_LAST = PEW'(input_SDIM - 1);
  localparam logic [CFW-1:0] CF_LAST = CFW'(CF - 1);
  localparam logic [IW-1:0]  IF_MAX  = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUIESCE = 2'd1,
    S_LOAD    = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [OB-1:0]  t_q, t_d;
  logic [PEW-1:0] pe_q, pe_d;
  logic [CFW-1:0] cf_q, cf_d;
  logic           err_q, err_d;
  logic [IW-1:0]  inflight_q, inflight_d;

  logic           gate;
  logic           in_xfer;
  logic           out_xfer;
  logic           beat;
  logic           last_word;
  logic [AW-1:0]  load_addr;

  // Any non-IDLE state holds the datapath input closed.
  assign gate          = (state_q != S_IDLE);
  assign up_tready_o   = core_tready_i & ~gate;
  assign core_tvalid_o = up_tvalid_i & ~gate;
  assign in_xfer       = core_tvalid_o & core_tready_i;
  assign out_xfer      = out_tvalid_i & out_tready_i;

  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign err_len_o      = err_q;
  assign wstrm_tready_o = (state_q == S_LOAD) & ~host_en_i;
  assign beat           = wstrm_tready_o & wstrm_tvalid_i;
  assign last_word      = (t_q == T_LAST) && (pe_q == PE_LAST) && (cf_q == CF_LAST);

  assign host_rack_o = cfg_rack_i;
  assign host_q_o    = cfg_q_i;

  // Degenerate single-CF / single-PE configurations drop those address fields.
  if (CFB > 0 && PEB > 0) begin : g_addr_cf_pe
    assign load_addr = {cf_q, pe_q, t_q};
  end else if (CFB > 0) begin : g_addr_cf
    assign load_addr = {cf_q, t_q};
  end else if (PEB > 0) begin : g_addr_pe
    assign load_addr = {pe_q, t_q};
  end else begin : g_addr_t
    assign load_addr = t_q;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (in_xfer && !out_xfer) begin
      inflight_d = inflight_q + IW'(1);
    end else if (out_xfer && !in_xfer) begin
      inflight_d = inflight_q - IW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    pe_d    = pe_q;
    cf_d    = cf_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d   = 1'b0;
          t_d     = '0;
          pe_d    = '0;
          cf_d    = '0;
          state_d = S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        if (inflight_q == '0) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (beat) begin
          if (last_word || wstrm_tlast_i) begin
            // Only tlast exactly on the final word is a clean load.
            err_d   = ~(last_word & wstrm_tlast_i);
            state_d = S_DONE;
          end else if (t_q == T_LAST) begin
            t_d = '0;
            if (pe_q == PE_LAST) begin
              pe_d = '0;
              cf_d = cf_q + CFW'(1);
            end else begin
              pe_d = pe_q + PEW'(1);
            end
          end else begin
            t_d = t_q + OB'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Host owns the cfg port whenever it strobes; the loader only fills idle slots.
  always_comb begin
    cfg_en_o = beat;
    cfg_we_o = beat;
    cfg_a_o  = load_addr;
    cfg_d_o  = wstrm_tdata_i;
    if (host_en_i) begin
      cfg_en_o = 1'b1;
      cfg_we_o = host_we_i;
      cfg_a_o  = host_a_i;
      cfg_d_o  = host_d_i;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      pe_q       <= '0;
      cf_q       <= '0;
      err_q      <= 1'b0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      pe_q       <= pe_d;
      cf_q       <= cf_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
    end
  end

  a_inflight_no_overflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    !(in_xfer && !out_xfer && inflight_q == IF_MAX));
  a_inflight_no_underflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    !(out_xfer && !in_xfer && inflight_q == '0));

endmodule
`default_nettype wire
